// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory between fetch and load/store, with bursts, range check and read timeout
module mem_arbiter #(
    parameter int DEPTH   = 1000000,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        i_grant,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_wtake,
    output logic        d_grant,
    output logic        d_rvalid,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    output logic        mem_wvalid,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out,
    input  logic        mem_rvalid
);
    localparam int IW = $clog2(TIMEOUT) + 1;
    typedef enum logic [2:0] {IDLE, REJ, CMD, WBURST, RBURST, DONE} state_t;
    state_t        state;
    logic          port, rr_d, fin;
    logic [3:0]    last_r, beat;
    logic [IW-1:0] idle;
    logic          pick_d, range_bad;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [3:0]    req_last;
    always_comb begin
        pick_d    = d_req && (!i_req || rr_d);
        req_addr  = pick_d ? d_addr : i_addr;
        req_size  = pick_d ? d_size : i_size;
        req_last  = req_size == 2'd0 ? 4'd0 : req_size == 2'd1 ? 4'd3 : req_size == 2'd2 ? 4'd7 : 4'd15;
        range_bad = ({1'b0, req_addr} + ((33'(req_last) + 33'd1) << 2)) > 33'(DEPTH);
    end
    assign mem_data_in = mem_wvalid ? d_wdata : 32'd0;
    // port: 1 = load/store owns the current transaction; fin marks the last read beat already shown
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            port <= 1'b0;
            rr_d <= 1'b1;
            fin <= 1'b0;
            last_r <= 4'd0;
            beat <= 4'd0;
            idle <= '0;
            i_grant <= 1'b0;
            i_rvalid <= 1'b0;
            i_done <= 1'b0;
            d_wtake <= 1'b0;
            d_grant <= 1'b0;
            d_rvalid <= 1'b0;
            d_done <= 1'b0;
            rdata <= 32'd0;
            err <= 1'b0;
            mem_address <= 32'd0;
            mem_access_size <= 2'd0;
            mem_rw <= 1'b0;
            mem_enable <= 1'b0;
            mem_wvalid <= 1'b0;
        end else begin
            i_grant <= 1'b0;
            i_rvalid <= 1'b0;
            i_done <= 1'b0;
            d_wtake <= 1'b0;
            d_grant <= 1'b0;
            d_rvalid <= 1'b0;
            d_done <= 1'b0;
            err <= 1'b0;
            mem_enable <= 1'b0;
            mem_wvalid <= 1'b0;
            case (state)
                IDLE: if (!mem_busy && (i_req || d_req)) begin
                    port <= pick_d;
                    mem_address <= {req_addr[31:2], 2'b00};
                    mem_access_size <= req_size;
                    mem_rw <= pick_d && d_rw;
                    last_r <= req_last;
                    if (range_bad) begin
                        state <= REJ;
                        i_done <= !pick_d;
                        d_done <= pick_d;
                        err <= 1'b1;
                    end else begin
                        state <= CMD;
                        mem_enable <= 1'b1;
                        i_grant <= !pick_d;
                        d_grant <= pick_d;
                        mem_wvalid <= pick_d && d_rw;
                        d_wtake <= pick_d && d_rw;
                    end
                end
                REJ: state <= IDLE;
                CMD: begin
                    beat <= mem_rw ? 4'd1 : 4'd0;
                    idle <= '0;
                    fin <= 1'b0;
                    if (!mem_rw) state <= RBURST;
                    else if (last_r == 4'd0) begin
                        state <= DONE;
                        d_done <= 1'b1;
                    end else begin
                        state <= WBURST;
                        mem_wvalid <= 1'b1;
                        d_wtake <= 1'b1;
                    end
                end
                WBURST: if (beat == last_r) begin
                    state <= DONE;
                    d_done <= 1'b1;
                end else begin
                    beat <= beat + 4'd1;
                    mem_wvalid <= 1'b1;
                    d_wtake <= 1'b1;
                end
                RBURST: if (fin) begin
                    state <= DONE;
                    i_done <= !port;
                    d_done <= port;
                end else if (mem_rvalid) begin
                    rdata <= mem_data_out;
                    i_rvalid <= !port;
                    d_rvalid <= port;
                    idle <= '0;
                    if (beat == last_r) fin <= 1'b1;
                    else beat <= beat + 4'd1;
                end else if (idle == IW'(TIMEOUT - 1)) begin
                    state <= DONE;
                    i_done <= !port;
                    d_done <= port;
                    err <= 1'b1;
                end else idle <= idle + IW'(1);
                DONE: begin
                    state <= IDLE;
                    rr_d <= !port;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for the fetch/load-store memory arbiter
module tb_mem_arbiter;
    localparam int DEPTH = 1000000;
    localparam int TO    = 16;
    logic        clock, reset;
    logic        i_req, i_grant, i_rvalid, i_done;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        d_req, d_rw, d_wtake, d_grant, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;
    logic        err, mem_rw, mem_enable, mem_wvalid, mem_busy, mem_rvalid;
    logic [1:0]  mem_access_size;
    int          passed = 0;
    int          total = 0;
    int          cyc;

    mem_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_grant(i_grant), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_wtake(d_wtake), .d_grant(d_grant), .d_rvalid(d_rvalid), .d_done(d_done),
        .rdata(rdata), .err(err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
        .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_wvalid(mem_wvalid),
        .mem_busy(mem_busy), .mem_data_out(mem_data_out), .mem_rvalid(mem_rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called in the CMD cycle of a read; feeds n beats, beat b preceded by b%gap idle cycles
    task automatic rd_burst(input logic dp, input int n, input int gap);
        mem_rvalid = 1'b1;
        mem_data_out = 32'hDEAD_DEAD;
        step();
        mem_rvalid = 1'b0;
        check("stray_rvalid", {31'd0, i_rvalid | d_rvalid}, 32'd0);
        for (int b = 0; b < n; b++) begin
            repeat (gap > 0 ? b % gap : 0) step();
            mem_rvalid = 1'b1;
            mem_data_out = 32'hC0DE_0000 + 32'(b);
            step();
            mem_rvalid = 1'b0;
            check("beat_rvalid", {31'd0, dp ? d_rvalid : i_rvalid}, 32'd1);
            check("beat_data", rdata, 32'hC0DE_0000 + 32'(b));
        end
        step();
        check("rd_done", {31'd0, dp ? d_done : i_done}, 32'd1);
        check("rd_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        {i_req, d_req, d_rw, mem_busy, mem_rvalid} = '0;
        {i_addr, d_addr, d_wdata, mem_data_out} = '0;
        {i_size, d_size} = '0;
        reset = 1'b1;
        step();
        step();
        check("rst_enable", {31'd0, mem_enable}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_flags", {26'd0, i_grant, d_grant, i_done, d_done, err, mem_wvalid}, 32'd0);
        reset = 1'b0;

        // four-beat store
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h100; d_size = 2'd1; d_wdata = 32'd1;
        step();
        check("wr_enable", {31'd0, mem_enable}, 32'd1);
        check("wr_grant", {31'd0, d_grant}, 32'd1);
        check("wr_addr", mem_address, 32'h100);
        check("wr_ctl", {29'd0, mem_rw, mem_access_size}, 32'd5);
        check("wr_beat0", {30'd0, mem_wvalid, d_wtake}, 32'd3);
        check("wr_data0", mem_data_in, 32'd1);
        d_req = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            d_wdata = 32'(k);
            #1;
            check("wr_beat", {29'd0, mem_enable, mem_wvalid, d_wtake}, 32'd3);
            check("wr_data", mem_data_in, 32'(k));
        end
        step();
        check("wr_done", {29'd0, d_done, err, mem_wvalid}, 32'd4);
        step();

        // tie after reset: d first, then i, then d again
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h300; i_size = 2'd0;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h200; d_size = 2'd0;
        step();
        check("tie1_grant", {30'd0, d_grant, i_grant}, 32'd2);
        check("tie1_addr", mem_address, 32'h200);
        d_req = 1'b0;
        rd_burst(1'b1, 1, 0);
        step();
        check("tie1_wait", {31'd0, i_grant}, 32'd0);
        step();
        check("tie1_igrant", {30'd0, d_grant, i_grant}, 32'd1);
        check("tie1_iaddr", mem_address, 32'h300);
        i_req = 1'b0;
        rd_burst(1'b0, 1, 0);
        step();
        i_req = 1'b1; d_req = 1'b1;
        step();
        check("tie2_grant", {30'd0, d_grant, i_grant}, 32'd2);
        i_req = 1'b0; d_req = 1'b0;
        rd_burst(1'b1, 1, 0);
        step();

        // range check at the top of memory
        d_req = 1'b1; d_rw = 1'b0; d_addr = DEPTH - 8; d_size = 2'd1;
        step();
        check("rej_done", {30'd0, d_done, err}, 32'd3);
        check("rej_noenable", {30'd0, mem_enable, d_grant}, 32'd0);
        d_req = 1'b0;
        step();
        check("rej_pulse", {31'd0, d_done}, 32'd0);
        d_req = 1'b1; d_addr = DEPTH - 16;
        step();
        check("edge_grant", {30'd0, mem_enable, d_grant}, 32'd3);
        check("edge_addr", mem_address, DEPTH - 16);
        d_req = 1'b0;
        rd_burst(1'b1, 4, 0);
        step();

        // 16-beat fetch with gaps, then a stalled fetch
        i_req = 1'b1; i_addr = 32'h1002; i_size = 2'd3;
        step();
        check("f16_grant", {31'd0, i_grant}, 32'd1);
        check("f16_addr", mem_address, 32'h1000);
        i_req = 1'b0;
        rd_burst(1'b0, 16, 3);
        step();
        i_req = 1'b1; i_addr = 32'h40; i_size = 2'd0;
        step();
        check("stall_grant", {31'd0, i_grant}, 32'd1);
        i_req = 1'b0;
        cyc = 0;
        while (!i_done && cyc < TO + 8) begin
            step();
            cyc++;
        end
        check("stall_done", {31'd0, i_done}, 32'd1);
        check("stall_err", {31'd0, err}, 32'd1);
        check("stall_lat", {31'd0, cyc >= TO && cyc <= TO + 2}, 32'd1);
        step();

        // reset during beat 2 of an 8-beat store
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h500; d_size = 2'd2; d_wdata = 32'h11;
        step();
        check("mid_grant", {31'd0, d_grant}, 32'd1);
        d_req = 1'b0;
        step();
        step();
        check("mid_beat2", {31'd0, mem_wvalid}, 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_outs", {24'd0, i_grant, d_grant, d_wtake, mem_wvalid, mem_enable, d_done, err, d_rvalid}, 32'd0);
        check("mid_rst_addr", mem_address, 32'd0);
        check("mid_rst_wdata", mem_data_in, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        mem_busy = 1'b1;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h80; d_size = 2'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("busy_hold", {30'd0, d_grant, mem_enable}, 32'd0);
        end
        mem_busy = 1'b0;
        step();
        check("busy_release", {30'd0, d_grant, mem_enable}, 32'd3);
        d_req = 1'b0;
        rd_burst(1'b1, 1, 0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
